// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end with a small prefetch queue.
// Owns the fetch PC, issues one word fetch at a time over req/ack, buffers
// {instr, pc4} pairs for decode and flushes/restarts on a redirect.
// Optional performance counters are enabled by defining IFQ_PERF_EN.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       im_req,
  output logic [31:0]                im_addr,
  input  logic                       im_ack,
  input  logic [31:0]                im_rdata,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc4,
  input  logic                       out_ready,
`ifdef IFQ_PERF_EN
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_dropped,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetchState_t;

  fetchState_t       state;
  fetchState_t       stateNext;
  logic [31:0]       fetchPc;
  logic [31:0]       dropAddr;
  logic [31:0]       redirectTarget;
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     wrPtr;
  logic [CW-1:0]     occupancy;
  logic [CW:0]       postCount;
  logic              doPush;
  logic              doPop;
  logic [31:0]       instrMem [DEPTH];
  logic [31:0]       pc4Mem   [DEPTH];

  assign redirectTarget = {redirect_pc[31:2], 2'b00};
  assign count          = occupancy;

  // Queue handshake qualifiers: a redirect discards both the push and the pop of its cycle
  always_comb begin
    doPush    = 1'b0;
    doPop     = 1'b0;
    postCount = '0;
    doPush    = (state == REQ) && im_ack && !redirect;
    doPop     = (occupancy != '0) && out_ready && !redirect;
    postCount = {1'b0, occupancy} + (CW+1)'(1) - (CW+1)'(doPop);
  end

  // Next-state logic: fetch only while there is room, and swallow the stale ack after a redirect
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (redirect || (occupancy < FULL)) stateNext = REQ;
      end
      REQ: begin
        if (redirect) begin
          stateNext = im_ack ? REQ : DROP;
        end else if (im_ack) begin
          stateNext = (postCount < {1'b0, FULL}) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (im_ack) stateNext = REQ;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: memory request side and queue head presentation
  always_comb begin
    im_req    = 1'b0;
    im_addr   = fetchPc;
    out_valid = 1'b0;
    out_instr = 32'h0;
    out_pc4   = 32'h0;
    im_req    = (state == REQ) || (state == DROP);
    if (state == DROP) im_addr = dropAddr;
    if (occupancy != '0) begin
      out_valid = 1'b1;
      out_instr = instrMem[rdPtr];
      out_pc4   = pc4Mem[rdPtr];
    end
  end

  // Control state: FSM register, fetch PC, stale address, pointers and occupancy
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      fetchPc   <= RESET_PC;
      dropAddr  <= RESET_PC;
      rdPtr     <= '0;
      wrPtr     <= '0;
      occupancy <= '0;
    end else begin
      state <= stateNext;
      if (redirect) begin
        fetchPc   <= redirectTarget;
        rdPtr     <= '0;
        wrPtr     <= '0;
        occupancy <= '0;
        if ((state == REQ) && !im_ack) dropAddr <= fetchPc;
      end else begin
        if (doPush) begin
          fetchPc <= fetchPc + 32'd4;
          wrPtr   <= wrPtr + PW'(1);
        end
        if (doPop) rdPtr <= rdPtr + PW'(1);
        case ({doPush, doPop})
          2'b10:   occupancy <= occupancy + CW'(1);
          2'b01:   occupancy <= occupancy - CW'(1);
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  // Queue storage: written on push; contents need no reset because empty slots are masked
  always_ff @(posedge clk) begin
    if (doPush) begin
      instrMem[wrPtr] <= im_rdata;
      pc4Mem[wrPtr]   <= fetchPc + 32'd4;
    end
  end

`ifdef IFQ_PERF_EN
  logic [32:0] dropAdd;
  logic [32:0] dropSum;

  // Dropped-work amount: flushed entries plus any ack whose data is thrown away
  always_comb begin
    dropAdd = '0;
    dropSum = '0;
    if (redirect) begin
      dropAdd = 33'(occupancy) + 33'((state != IDLE) && im_ack);
    end else if ((state == DROP) && im_ack) begin
      dropAdd = 33'd1;
    end
    dropSum = {1'b0, perf_dropped} + dropAdd;
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perf_fetched <= 32'h0;
      perf_dropped <= 32'h0;
    end else begin
      if (doPush && (perf_fetched != 32'hFFFFFFFF)) perf_fetched <= perf_fetched + 32'd1;
      perf_dropped <= dropSum[32] ? 32'hFFFFFFFF : dropSum[31:0];
    end
  end
`endif

endmodule
